codificador_programa: RTL and testbench
=======================================

CODIFICADOR_PROGRAMA -- requirements
Module: codificador_programa

Interface
REQ-001 Parameter NPALAVRAS, default 32, instruction-memory depth in 32-bit words.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  instruction fields valid.
REQ-005 in_ready  out  1  block can accept fields this cycle.
REQ-006 op  in  3  0=LW 1=SW 2=SUB 3=XOR 4=ADDI 5=SRL 6=BEQ 7=illegal.
REQ-007 rd, rs1, rs2  in  5 each  register indices.
REQ-008 immediate  in  12  I/S immediate; for BEQ, offset bits [12:1].
REQ-009 fim  in  1  with accepted fields: last instruction of program.
REQ-010 mem_we  out  1  one-cycle instruction-memory write strobe.
REQ-011 mem_addr  out  32  byte address, word aligned.
REQ-012 mem_wdata  out  32  encoded instruction word.
REQ-013 pronto  out  1  program plus terminator written.
REQ-014 erro  out  1  sticky: illegal op received.
REQ-015 contagem  out  6  words written, terminator included.

Function
REQ-016 Handshake: transfer when in_valid && in_ready; in_ready high only in IDLE.
REQ-017 FSM: IDLE -> ENCODE on transfer; ENCODE -> WRITE; WRITE -> TERM if fim was latched or contagem+1 == NPALAVRAS-1, else IDLE; TERM -> DONE; DONE holds until rst.
REQ-018 Latency: transfer at edge N gives mem_we high during cycle N+2, with mem_addr = 4*contagem (pre-increment).
REQ-019 Encoding: LW opcode 0000011 f3 010 I-type; ADDI 0010011 f3 000 I-type; SW 0100011 f3 010 S-type with imm[11:5] in [31:25] and imm[4:0] in [11:7].
REQ-020 Encoding: SUB 0110011 f7 0100000 f3 000; XOR f7 0 f3 100; SRL f7 0 f3 101.
REQ-021 Encoding: BEQ 1100011 f3 000; [31]=imm[11], [30:25]=imm[9:4], [11:8]=imm[3:0], [7]=imm[10].
REQ-022 Unused fields are ignored: rd for SW/BEQ, rs2 for I-types.
REQ-023 op=7: erro set, no write, return to IDLE; a latched fim still leads to TERM.
REQ-024 TERM writes 0x00000000 at the next address; the datapath treats a zero word as end of program.
REQ-025 contagem increments on every mem_we; mem_addr wraps never, because capacity stops at NPALAVRAS-1 instructions.
REQ-026 mem_we is never high in IDLE, ENCODE or DONE.

Reset
REQ-027 On rst: state IDLE; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; pronto=0; erro=0; contagem=0.
REQ-028 rst mid-ENCODE, WRITE or TERM aborts with no further write; rst has priority over a transfer.

Structure
REQ-029 The op codes, opcode/funct3/funct7 constants and FSM state encodings belong in a shared package, also used by the instruction-decode logic.
REQ-030 One combinational sub-module codifica_campos maps op and fields to a 32-bit word; the FSM, counter and handshake stay in the top.

Verification
REQ-031 Case 1: ADDI rd=1 rs1=0 imm=5, fim=0 -> mem_we at N+2, addr 0x0, wdata 0x00500093, contagem=1.
REQ-032 Case 2: SUB rd=3 rs1=1 rs2=2, then LW rd=5 rs1=2 imm=8 -> wdata 0x402081B3 at addr 0x0, then 0x00812283 at addr 0x4.
REQ-033 Case 3: SW rs2=5 rs1=2 imm=12, then BEQ rs1=1 rs2=2 imm=0xFFC with fim=1 -> 0x00512623, then 0xFE208CE3, then 0x00000000 at 0x8; pronto=1, contagem=3, in_ready=0.
REQ-034 Case 4: NPALAVRAS-1 back-to-back ADDIs with fim=0 -> terminator auto-written at addr 4*(NPALAVRAS-1); pronto=1; further in_valid is ignored.
REQ-035 Case 5: op=7 -> erro=1, no mem_we; next legal op is written at addr 0x0.
REQ-036 Case 6: rst asserted the cycle after a transfer -> no mem_we; all outputs return to reset values next edge.

Source files
------------

// File: rtl/codificador_programa_pkg.sv
// Shared op codes, RISC-V opcode/funct constants, FSM states and field payload
// for the instruction encoder.
package codificador_programa_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 3;
  localparam int unsigned RW   = 5;
  localparam int unsigned IMMW = 12;
  localparam int unsigned CNTW = 6;

  typedef enum logic [OPW-1:0] {
    OP_LW     = 3'd0,
    OP_SW     = 3'd1,
    OP_SUB    = 3'd2,
    OP_XOR    = 3'd3,
    OP_ADDI   = 3'd4,
    OP_SRL    = 3'd5,
    OP_BEQ    = 3'd6,
    OP_ILEGAL = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENCODE = 3'd1,
    ST_WRITE  = 3'd2,
    ST_TERM   = 3'd3,
    ST_DONE   = 3'd4
  } estado_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_SUB  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  typedef struct packed {
    op_e             op;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [IMMW-1:0] imm;
    logic            fim;
  } campos_t;

  // Byte address of a word index.
  function automatic logic [XLEN-1:0] endereco(input logic [CNTW-1:0] idx);
    return XLEN'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/codificador_programa_campos.sv
// Combinational encoder: latched op and fields to a 32-bit RISC-V word.
module codifica_campos
  import codificador_programa_pkg::*;
(
  input  campos_t         campos,
  output logic [XLEN-1:0] palavra_c,
  output logic            legal_c
);

  always_comb begin
    palavra_c = '0;
    legal_c   = 1'b1;
    case (campos.op)
      OP_LW:   palavra_c = {campos.imm, campos.rs1, F3_LW, campos.rd, OPC_LOAD};
      OP_ADDI: palavra_c = {campos.imm, campos.rs1, F3_ADDI, campos.rd, OPC_OPIMM};
      OP_SW:   palavra_c = {campos.imm[11:5], campos.rs2, campos.rs1, F3_SW,
                            campos.imm[4:0], OPC_STORE};
      OP_SUB:  palavra_c = {F7_SUB, campos.rs2, campos.rs1, F3_SUB, campos.rd, OPC_OP};
      OP_XOR:  palavra_c = {F7_BASE, campos.rs2, campos.rs1, F3_XOR, campos.rd, OPC_OP};
      OP_SRL:  palavra_c = {F7_BASE, campos.rs2, campos.rs1, F3_SRL, campos.rd, OPC_OP};
      // immediate holds branch offset bits [12:1]
      OP_BEQ:  palavra_c = {campos.imm[11], campos.imm[9:4], campos.rs2, campos.rs1,
                            F3_BEQ, campos.imm[3:0], campos.imm[10], OPC_BRANCH};
      default: legal_c   = 1'b0;
    endcase
  end

endmodule

// File: rtl/codificador_programa.sv
// Accepts instruction fields one at a time, writes encoded words to instruction
// memory and appends a zero terminator when the program ends or memory fills.
module codificador_programa
  import codificador_programa_pkg::*;
#(
  parameter int unsigned NPALAVRAS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rs1,
  input  logic [RW-1:0]    rs2,
  input  logic [IMMW-1:0]  immediate,
  input  logic             fim,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic             pronto,
  output logic             erro,
  output logic [CNTW-1:0]  contagem
);

  localparam logic [CNTW-1:0] ULTIMO = CNTW'(NPALAVRAS - 1);

  estado_e         estado_q, estado_d;
  campos_t         campos_q, campos_d;
  logic            in_ready_q, in_ready_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            pronto_q, pronto_d;
  logic            erro_q, erro_d;
  logic [CNTW-1:0] contagem_q, contagem_d;
  logic [XLEN-1:0] palavra_c;
  logic            legal_c;

  codifica_campos u_codifica (
    .campos    (campos_q),
    .palavra_c (palavra_c),
    .legal_c   (legal_c)
  );

  // Next state, write strobe and word counter.
  always_comb begin
    estado_d    = estado_q;
    campos_d    = campos_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pronto_d    = pronto_q;
    erro_d      = erro_q;
    contagem_d  = contagem_q + CNTW'(mem_we_q);
    case (estado_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          campos_d.op  = op_e'(op);
          campos_d.rd  = rd;
          campos_d.rs1 = rs1;
          campos_d.rs2 = rs2;
          campos_d.imm = immediate;
          campos_d.fim = fim;
          estado_d     = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        estado_d = ST_WRITE;
        if (legal_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = endereco(contagem_q);
          mem_wdata_d = palavra_c;
        end else begin
          erro_d = 1'b1;
        end
      end
      ST_WRITE: begin
        // contagem_d already counts the word being written this cycle
        if (campos_q.fim || (contagem_d == ULTIMO)) begin
          estado_d    = ST_TERM;
          mem_we_d    = 1'b1;
          mem_addr_d  = endereco(contagem_d);
          mem_wdata_d = '0;
        end else begin
          estado_d = ST_IDLE;
        end
      end
      ST_TERM: begin
        estado_d = ST_DONE;
        pronto_d = 1'b1;
      end
      ST_DONE: estado_d = ST_DONE;
      default: estado_d = ST_IDLE;
    endcase
    in_ready_d = (estado_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= ST_IDLE;
      campos_q    <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
      contagem_q  <= '0;
    end else begin
      estado_q    <= estado_d;
      campos_q    <= campos_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pronto_q    <= pronto_d;
      erro_q      <= erro_d;
      contagem_q  <= contagem_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign contagem  = contagem_q;

endmodule

// File: tb/tb_codificador_programa.sv
// Directed bench for codificador_programa with hand-computed instruction words.
module tb_codificador_programa;

  localparam int unsigned NP = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [11:0] immediate = '0;
  logic        fim = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        pronto, erro;
  logic [5:0]  contagem;

  int n_cmp = 0;
  int n_err = 0;

  codificador_programa #(.NPALAVRAS(NP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate), .fim(fim),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pronto(pronto), .erro(erro), .contagem(contagem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
    check({tag, " mem_we"},    32'(mem_we),    32'd0);
    check({tag, " mem_addr"},  mem_addr,       32'd0);
    check({tag, " mem_wdata"}, mem_wdata,      32'd0);
    check({tag, " pronto"},    32'(pronto),    32'd0);
    check({tag, " erro"},      32'(erro),      32'd0);
    check({tag, " contagem"},  32'(contagem),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Transfer one instruction; checks ENCODE cycle quiet and WRITE cycle outputs.
  task automatic xfer(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [11:0] im, input logic f,
                      input logic we_exp, input logic [31:0] a_exp,
                      input logic [31:0] w_exp, input string tag);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    op = o; rd = d; rs1 = s1; rs2 = s2; immediate = im; fim = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    fim = 1'b0;
    @(negedge clk);
    check({tag, " we N+1"}, 32'(mem_we), 32'd0);
    @(negedge clk);
    check({tag, " we N+2"}, 32'(mem_we), 32'(we_exp));
    if (we_exp) begin
      check({tag, " addr"},  mem_addr,  a_exp);
      check({tag, " wdata"}, mem_wdata, w_exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // ADDI x1, x0, 5
    xfer(3'd4, 5'd1, 5'd0, 5'd0, 12'd5, 1'b0, 1'b1, 32'h0, 32'h00500093, "c1");
    @(negedge clk);
    check("c1 contagem", 32'(contagem), 32'd1);
    check("c1 idle we",  32'(mem_we),   32'd0);

    // reset the cycle after a transfer aborts the write
    op = 3'd4; rd = 5'd7; rs1 = 5'd0; immediate = 12'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("c6");
    @(negedge clk);
    check("c6 no we", 32'(mem_we), 32'd0);

    // SUB x3,x1,x2 then LW x5,8(x2)
    xfer(3'd2, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, 1'b1, 32'h0, 32'h402081B3, "c2 sub");
    xfer(3'd0, 5'd5, 5'd2, 5'd0, 12'd8, 1'b0, 1'b1, 32'h4, 32'h00812283, "c2 lw");

    // SW x5,12(x2) then BEQ x1,x2,-8 with fim
    do_reset();
    xfer(3'd1, 5'd0, 5'd2, 5'd5, 12'd12, 1'b0, 1'b1, 32'h0, 32'h00512623, "c3 sw");
    xfer(3'd6, 5'd0, 5'd1, 5'd2, 12'hFFC, 1'b1, 1'b1, 32'h4, 32'hFE208CE3, "c3 beq");
    @(negedge clk);
    check("c3 term we",    32'(mem_we), 32'd1);
    check("c3 term addr",  mem_addr,    32'h8);
    check("c3 term wdata", mem_wdata,   32'h0);
    @(negedge clk);
    check("c3 pronto",   32'(pronto),   32'd1);
    check("c3 contagem", 32'(contagem), 32'd3);
    check("c3 in_ready", 32'(in_ready), 32'd0);
    check("c3 done we",  32'(mem_we),   32'd0);

    // illegal op then ADDI x2, x0, 1
    do_reset();
    xfer(3'd7, 5'd1, 5'd1, 5'd1, 12'd1, 1'b0, 1'b0, 32'h0, 32'h0, "c5 ilegal");
    check("c5 erro", 32'(erro), 32'd1);
    @(negedge clk);
    check("c5 contagem", 32'(contagem), 32'd0);
    xfer(3'd4, 5'd2, 5'd0, 5'd0, 12'd1, 1'b0, 1'b1, 32'h0, 32'h00100113, "c5 addi");
    check("c5 erro sticky", 32'(erro), 32'd1);

    // fill memory: NP-1 ADDIs then automatic terminator
    do_reset();
    for (int i = 0; i < int'(NP) - 1; i++) begin
      xfer(3'd4, 5'd1, 5'd0, 5'd0, 12'(i), 1'b0, 1'b1, 32'(4 * i),
           {12'(i), 5'd0, 3'b000, 5'd1, 7'b0010011}, "c4 addi");
    end
    @(negedge clk);
    check("c4 term we",    32'(mem_we), 32'd1);
    check("c4 term addr",  mem_addr,    32'(4 * (NP - 1)));
    check("c4 term wdata", mem_wdata,   32'h0);
    @(negedge clk);
    check("c4 pronto",   32'(pronto),   32'd1);
    check("c4 contagem", 32'(contagem), 32'(NP));
    op = 3'd4; rd = 5'd1; immediate = 12'd3; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("c4 ignored we",  32'(mem_we),   32'd0);
      check("c4 in_ready",    32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("c4 contagem hold", 32'(contagem), 32'(NP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
